// File: rtl/uart_cmd_decoder.sv
// Unloads bytes from the UART receiver and frames SYNC/ADDR/DATA/CHK packets into register writes.
// Latency: byte_rdy to internal byte strobe 3 cycles, CHK byte to wr_en 1 cycle; receiver is throttled by one uld_rx_data per byte.
module uart_cmd_decoder #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         DATA_BYTES     = 2,
    parameter int         TIMEOUT_CYCLES = 357000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    byte_rdy,
    input  logic [7:0]              rx_data,
    output logic                    uld_rx_data,
    output logic                    wr_en,
    output logic [7:0]              wr_addr,
    output logic [8*DATA_BYTES-1:0] wr_data,
    output logic                    chk_err,
    output logic                    timeout_err,
    output logic [7:0]              err_count,
    output logic                    busy
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] D_LAST = IW'(DATA_BYTES - 1);

    typedef enum logic [1:0] {F_IDLE, F_ULD, F_CAP} fstate_t;
    typedef enum logic [1:0] {P_HUNT, P_ADDR, P_DATA, P_CHK} pstate_t;

    fstate_t         fstate;
    pstate_t         pstate;
    logic            byte_v;
    logic [7:0]      byte_q;
    logic [7:0]      sh_addr;
    logic [DW-1:0]   sh_data;
    logic [7:0]      chk_acc;
    logic [IW-1:0]   didx;
    logic [TW-1:0]   tcnt;

    // Receiver handshake: one unload strobe, then capture rx_data once it has been loaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fstate      <= F_IDLE;
            uld_rx_data <= 1'b0;
            byte_v      <= 1'b0;
            byte_q      <= 8'h00;
        end else begin
            uld_rx_data <= 1'b0;
            byte_v      <= 1'b0;
            case (fstate)
                F_IDLE: begin
                    if (byte_rdy) begin
                        uld_rx_data <= 1'b1;
                        fstate      <= F_ULD;
                    end
                end
                F_ULD: fstate <= F_CAP;
                F_CAP: begin
                    byte_q <= rx_data;
                    byte_v <= 1'b1;
                    fstate <= F_IDLE;
                end
                default: fstate <= F_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pstate      <= P_HUNT;
            sh_addr     <= 8'h00;
            sh_data     <= '0;
            chk_acc     <= 8'h00;
            didx        <= '0;
            tcnt        <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= 8'h00;
            wr_data     <= '0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
            if (pstate == P_HUNT) begin
                tcnt <= '0;
                if (byte_v && byte_q == SYNC_BYTE)
                    pstate <= P_ADDR;
            end else if (tcnt == T_LAST) begin
                // Timeout wins over a byte arriving on the same edge; that byte is dropped.
                timeout_err <= 1'b1;
                pstate      <= P_HUNT;
                tcnt        <= '0;
            end else if (byte_v) begin
                tcnt <= '0;
                case (pstate)
                    P_ADDR: begin
                        sh_addr <= byte_q;
                        chk_acc <= byte_q;
                        didx    <= '0;
                        pstate  <= P_DATA;
                    end
                    P_DATA: begin
                        sh_data <= (sh_data << 8) | DW'(byte_q);
                        chk_acc <= chk_acc ^ byte_q;
                        if (didx == D_LAST)
                            pstate <= P_CHK;
                        else
                            didx <= didx + 1'b1;
                    end
                    P_CHK: begin
                        if (byte_q == chk_acc) begin
                            wr_en   <= 1'b1;
                            wr_addr <= sh_addr;
                            wr_data <= sh_data;
                        end else begin
                            chk_err <= 1'b1;
                        end
                        pstate <= P_HUNT;
                    end
                    default: pstate <= P_HUNT;
                endcase
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // Counts the registered error pulses, so it trails them by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_count <= 8'h00;
        else if ((chk_err || timeout_err) && err_count != 8'hFF)
            err_count <= err_count + 8'h01;
    end

    assign busy = (pstate != P_HUNT);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomised packet streams through a behavioural UART receiver, checked against a packet-level model.
module tb_uart_cmd_decoder;
    localparam int DB = 2;
    localparam int T  = 2000;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          byte_rdy = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          uld_rx_data, wr_en, chk_err, timeout_err, busy;
    logic [7:0]    wr_addr, err_count;
    logic [8*DB-1:0] wr_data;

    uart_cmd_decoder #(.SYNC_BYTE(SYNC), .DATA_BYTES(DB), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .byte_rdy(byte_rdy), .rx_data(rx_data),
        .uld_rx_data(uld_rx_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .chk_err(chk_err), .timeout_err(timeout_err), .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0, check_cnt = 0;
    int cyc = 0;
    int n_uld = 0, wide_uld = 0, n_wr = 0, n_chk = 0, n_to = 0;
    int last_uld_cyc = 0, to_cyc = 0;
    logic uld_prev = 1'b0;

    // Expected state, derived only from the byte streams sent
    logic [7:0]      exp_addr = 8'h00;
    logic [8*DB-1:0] exp_data = '0;
    int exp_wr = 0, exp_chk = 0, exp_to = 0, exp_err = 0;
    bq_t stim;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (uld_rx_data && !uld_prev) begin
            n_uld++;
            last_uld_cyc = cyc;
        end
        if (uld_rx_data && uld_prev) wide_uld++;
        uld_prev = uld_rx_data;
        if (wr_en) n_wr++;
        if (chk_err) n_chk++;
        if (timeout_err) begin
            n_to++;
            to_cyc = cyc;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        repeat (gap) @(posedge clk);
        #1 byte_rdy = 1'b1;
        k = 0;
        @(negedge clk);
        while (!uld_rx_data && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!uld_rx_data) begin
            check_cnt++;
            $display("FAIL uld_wait: uld_rx_data=%b required 1 within 20 cycles", uld_rx_data);
        end
        @(posedge clk);
        #1 rx_data = b;
        byte_rdy = 1'b0;
    endtask

    task automatic send_stim(input int gmin, input int gmax);
        foreach (stim[i]) send_byte(stim[i], $urandom_range(gmax, gmin));
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    // Packet-level reference: scan for SYNC, slice fixed-length packets, XOR-check.
    task automatic model_stream(input bq_t q);
        int i;
        logic [7:0] a, c;
        logic [8*DB-1:0] d;
        i = 0;
        while (i < q.size()) begin
            if (q[i] !== SYNC || i + DB + 2 >= q.size()) begin
                i++;
                continue;
            end
            a = q[i+1];
            c = a;
            d = '0;
            for (int k = 0; k < DB; k++) begin
                d = (d << 8) | (8*DB)'(q[i+2+k]);
                c = c ^ q[i+2+k];
            end
            if (c == q[i+DB+2]) begin
                exp_wr++;
                exp_addr = a;
                exp_data = d;
            end else begin
                exp_chk++;
                if (exp_err < 255) exp_err++;
            end
            i += DB + 3;
        end
    endtask

    task automatic add_packet(input logic [7:0] a, input logic [8*DB-1:0] d, input bit good);
        logic [7:0] c, b;
        c = a;
        stim.push_back(SYNC);
        stim.push_back(a);
        for (int k = DB - 1; k >= 0; k--) begin
            b = d[8*k +: 8];
            stim.push_back(b);
            c = c ^ b;
        end
        stim.push_back(good ? c : (c ^ 8'h01));
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_cnt++;
        if ({uld_rx_data, wr_en, wr_addr, wr_data, chk_err, timeout_err, err_count, busy} !== '0)
            $display("FAIL reset_outputs: got addr=%h data=%h err=%0d busy=%b required all 0",
                     wr_addr, wr_data, err_count, busy);
        else pass_cnt++;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_single();
        stim = {8'hA5, 8'h12, 8'hBE, 8'hEF, 8'h43};
        model_stream(stim);
        send_stim(1000, 1000);
        check_cnt++;
        if (n_wr !== exp_wr || exp_wr !== 1) $display("FAIL single_wr: got %0d writes required %0d", n_wr, exp_wr);
        else pass_cnt++;
        check_cnt++;
        if (wr_addr !== 8'h12 || wr_data !== 16'hBEEF)
            $display("FAIL single_val: got %h/%h required 12/BEEF", wr_addr, wr_data);
        else pass_cnt++;
        check_cnt++;
        if (err_count !== 8'd0) $display("FAIL single_err: got %0d required 0", err_count);
        else pass_cnt++;
    endtask

    task automatic test_bad_chk();
        stim = {8'hA5, 8'h12, 8'hBE, 8'hEF, 8'h44};
        model_stream(stim);
        send_stim(2, 10);
        check_cnt++;
        if (n_chk !== exp_chk || n_wr !== exp_wr)
            $display("FAIL badchk_pulses: got chk=%0d wr=%0d required chk=%0d wr=%0d", n_chk, n_wr, exp_chk, exp_wr);
        else pass_cnt++;
        check_cnt++;
        if (wr_addr !== exp_addr || wr_data !== exp_data || err_count !== 8'(exp_err))
            $display("FAIL badchk_hold: got %h/%h err=%0d required %h/%h err=%0d",
                     wr_addr, wr_data, err_count, exp_addr, exp_data, exp_err);
        else pass_cnt++;
        stim = {8'hA5, 8'h01, 8'h00, 8'h02, 8'h03};
        model_stream(stim);
        send_stim(0, 5);
        check_cnt++;
        if (wr_addr !== 8'h01 || wr_data !== 16'h0002 || n_wr !== exp_wr)
            $display("FAIL badchk_next: got %h/%h wr=%0d required 01/0002 wr=%0d", wr_addr, wr_data, n_wr, exp_wr);
        else pass_cnt++;
    endtask

    task automatic test_garbage();
        stim = {8'h00, 8'hFF, 8'h5A};
        add_packet(8'($urandom), 16'($urandom), 1'b1);
        model_stream(stim);
        send_stim(0, 20);
        check_cnt++;
        if (n_wr !== exp_wr || n_chk !== exp_chk || wr_addr !== exp_addr || wr_data !== exp_data)
            $display("FAIL garbage: got wr=%0d chk=%0d %h/%h required wr=%0d chk=%0d %h/%h",
                     n_wr, n_chk, wr_addr, wr_data, exp_wr, exp_chk, exp_addr, exp_data);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int k;
        send_byte(8'hA5, 2);
        send_byte(8'h12, 2);
        send_byte(8'hBE, 2);
        k = 0;
        while (n_to == exp_to && k < T + 10) begin
            @(negedge clk);
            k++;
        end
        exp_to++;
        if (exp_err < 255) exp_err++;
        check_cnt++;
        if (n_to !== exp_to) $display("FAIL timeout_fire: got %0d pulses required %0d", n_to, exp_to);
        else pass_cnt++;
        // uld cycle u -> byte strobe u+2 -> consumed at the following edge -> pulse T cycles later
        check_cnt++;
        if (to_cyc - last_uld_cyc !== T + 3)
            $display("FAIL timeout_time: got %0d cycles required %0d", to_cyc - last_uld_cyc, T + 3);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        check_cnt++;
        if (busy !== 1'b0 || n_wr !== exp_wr || err_count !== 8'(exp_err))
            $display("FAIL timeout_after: got busy=%b wr=%0d err=%0d required 0/%0d/%0d",
                     busy, n_wr, err_count, exp_wr, exp_err);
        else pass_cnt++;
        stim = {};
        add_packet(8'h77, 16'h1234, 1'b1);
        model_stream(stim);
        send_stim(0, 3);
        check_cnt++;
        if (wr_addr !== 8'h77 || wr_data !== 16'h1234 || n_wr !== exp_wr)
            $display("FAIL timeout_next: got %h/%h required 77/1234", wr_addr, wr_data);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int u0;
        for (int g = 0; g <= 2; g += 2) begin
            stim = {};
            for (int p = 0; p < 4; p++) add_packet(8'($urandom), 16'($urandom), 1'b1);
            u0 = n_uld;
            model_stream(stim);
            send_stim(g, g);
            check_cnt++;
            if (n_uld - u0 !== stim.size() || wide_uld !== 0)
                $display("FAIL b2b_uld gap%0d: got %0d pulses wide=%0d required %0d wide=0",
                         g, n_uld - u0, wide_uld, stim.size());
            else pass_cnt++;
            check_cnt++;
            if (n_wr !== exp_wr || wr_addr !== exp_addr || wr_data !== exp_data)
                $display("FAIL b2b_data gap%0d: got wr=%0d %h/%h required wr=%0d %h/%h",
                         g, n_wr, wr_addr, wr_data, exp_wr, exp_addr, exp_data);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [7:0] g;
        stim = {};
        for (int p = 0; p < 20; p++) begin
            repeat ($urandom_range(2, 0)) begin
                g = 8'($urandom);
                if (g == SYNC) g = 8'h00;
                stim.push_back(g);
            end
            add_packet(8'($urandom), 16'($urandom), ($urandom_range(3, 0) != 0));
        end
        model_stream(stim);
        send_stim(0, 30);
        check_cnt++;
        if (n_wr !== exp_wr || n_chk !== exp_chk || n_to !== exp_to)
            $display("FAIL random_counts: got wr=%0d chk=%0d to=%0d required %0d/%0d/%0d",
                     n_wr, n_chk, n_to, exp_wr, exp_chk, exp_to);
        else pass_cnt++;
        check_cnt++;
        if (wr_addr !== exp_addr || wr_data !== exp_data || err_count !== 8'(exp_err) || busy !== 1'b0)
            $display("FAIL random_state: got %h/%h err=%0d busy=%b required %h/%h err=%0d busy=0",
                     wr_addr, wr_data, err_count, busy, exp_addr, exp_data, exp_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5, 1);
        send_byte(8'h12, 1);
        send_byte(8'hBE, 1);
        repeat (4) @(negedge clk);
        check_cnt++;
        if (busy !== 1'b1) $display("FAIL midrst_busy: got %b required 1", busy);
        else pass_cnt++;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_cnt++;
        if ({uld_rx_data, wr_en, wr_addr, wr_data, chk_err, timeout_err, err_count, busy} !== '0)
            $display("FAIL midrst_async: got addr=%h data=%h err=%0d busy=%b required all 0",
                     wr_addr, wr_data, err_count, busy);
        else pass_cnt++;
        exp_addr = 8'h00;
        exp_data = '0;
        exp_err = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        stim = {};
        add_packet(8'h3C, 16'hA5A5, 1'b1);
        model_stream(stim);
        send_stim(0, 4);
        check_cnt++;
        if (wr_addr !== 8'h3C || wr_data !== 16'hA5A5 || n_wr !== exp_wr || err_count !== 8'd0)
            $display("FAIL midrst_next: got %h/%h wr=%0d err=%0d required 3C/A5A5 wr=%0d err=0",
                     wr_addr, wr_data, n_wr, err_count, exp_wr);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        stim = {};
        for (int p = 0; p < 300; p++) add_packet(8'($urandom), 16'($urandom), 1'b0);
        model_stream(stim);
        send_stim(0, 0);
        check_cnt++;
        if (err_count !== 8'd255 || exp_err !== 255)
            $display("FAIL saturate: got %0d required 255", err_count);
        else pass_cnt++;
        check_cnt++;
        if (n_chk !== exp_chk || n_wr !== exp_wr)
            $display("FAIL saturate_pulses: got chk=%0d wr=%0d required %0d/%0d", n_chk, n_wr, exp_chk, exp_wr);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_bad_chk();
        test_garbage();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream.
- Drives the receiver's unload strobe, captures each byte, and frames fixed-length command packets: SYNC, ADDR, DATA (MSB first), CHK.
- On a valid packet, issues a single-cycle register-write strobe to the board register file.
- Bad checksum and inter-byte timeout are flagged and counted.

Parameters:
- SYNC_BYTE, 8'hA5, packet start marker.
- DATA_BYTES, 2, number of data bytes per packet (1..4); wr_data width = 8*DATA_BYTES.
- TIMEOUT_CYCLES, 357000, maximum clk cycles allowed between bytes inside a packet. Counter width is the minimum needed to hold this value.

Ports:
- clk  in  1  system clock, same clock as the UART receiver.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- byte_rdy  in  1  receiver byte-ready flag.
- rx_data  in  8  receiver output byte, valid the cycle after uld_rx_data.
- uld_rx_data  out  1  single-cycle unload strobe to the receiver.
- wr_en  out  1  single-cycle register-write strobe.
- wr_addr  out  8  write address, held stable until the next write.
- wr_data  out  8*DATA_BYTES  write data, held stable until the next write.
- chk_err  out  1  single-cycle pulse on checksum mismatch.
- timeout_err  out  1  single-cycle pulse on inter-byte timeout.
- err_count  out  8  saturating count of chk_err plus timeout_err events.
- busy  out  1  high whenever the packet FSM is not in HUNT.

Behaviour:

Reset
- reset=0 asynchronously clears all registers and outputs to 0.
- Both FSMs go to their idle states: fetch FSM to F_IDLE, packet FSM to HUNT.
- reset may be asserted mid-packet; the partial packet is discarded and no wr_en is issued.

Fetch FSM (F_IDLE, F_ULD, F_CAP)
- F_IDLE: if byte_rdy=1, assert uld_rx_data on the next cycle and go to F_ULD.
- F_ULD: uld_rx_data returns to 0; go to F_CAP. The receiver clears byte_rdy and loads rx_data at the end of this cycle.
- F_CAP: latch rx_data, pulse the internal strobe byte_v for 1 cycle, return to F_IDLE.
- byte_rdy is ignored outside F_IDLE, so there is exactly one uld_rx_data pulse per byte.
- Latency: byte_rdy rise to byte_v is 3 cycles. Minimum spacing between uld_rx_data pulses is 3 cycles.

Packet FSM (HUNT, ADDR, DATA, CHK)
- HUNT: on byte_v with byte==SYNC_BYTE, go to ADDR. Any other byte is dropped silently (no error).
- ADDR: on byte_v, latch the address into a shadow register, set chk_acc=byte, go to DATA with data index=0.
- DATA: on byte_v, shift the byte into the shadow data register (first byte received becomes the MSB) and set chk_acc ^= byte. After the DATA_BYTES-th byte, go to CHK.
- CHK: on byte_v:
  - If byte==chk_acc: on the next cycle load wr_addr/wr_data from the shadow registers and pulse wr_en=1 for 1 cycle.
  - Otherwise: pulse chk_err=1 for 1 cycle; wr_addr/wr_data are unchanged.
  - Either way, return to HUNT.
- A SYNC_BYTE value received in ADDR, DATA or CHK is treated as ordinary payload; there is no resynchronisation.

Timeout
- The counter clears on each byte_v and when in HUNT.
- It increments every cycle while in any state other than HUNT.
- When it reaches TIMEOUT_CYCLES: pulse timeout_err for 1 cycle, go to HUNT, issue no write.
- A byte_v in the same cycle as the timeout is lost; the timeout takes priority.

Error counter
- err_count increments by 1 on each chk_err or timeout_err pulse and saturates at 255 (no wrap).
- chk_err and timeout_err cannot fire in the same cycle.

Test Plan:
1. Packet A5 12 BE EF 43 (0x12^0xBE^0xEF=0x43), bytes spaced about 1000 cycles apart → exactly one wr_en pulse, wr_addr=0x12, wr_data=0xBEEF, err_count=0.
2. Packet A5 12 BE EF 44 → chk_err pulses once, no wr_en, wr_addr/wr_data keep their previous values, err_count=1. A following valid packet A5 01 00 02 03 → write with wr_addr=0x01, wr_data=0x0002.
3. Leading garbage 00 FF 5A, then a valid packet → only the valid packet is written; no error pulses.
4. A5 12 BE, then silence for TIMEOUT_CYCLES+10 → timeout_err pulses at exactly TIMEOUT_CYCLES after the 0xBE byte_v, busy=0, no write. A next valid packet is accepted.
5. Handshake: byte_rdy held high from a behavioural receiver model → uld_rx_data is exactly 1 cycle wide, the captured byte equals rx_data sampled 2 cycles after byte_rdy rise, one pulse per byte. Back-to-back bytes arriving every 4 cycles are all captured.
6. Assert reset=0 asynchronously mid-DATA, then release → all outputs are 0 immediately, and a subsequent valid packet writes correctly. Drive 300 bad-checksum packets → err_count saturates at 255.
